// File: rtl/ee354_project_dirn_queue.sv
// Direction-command buffer for the snake game.
// Collects legal button presses between game ticks and commits one per
// rising edge of Speed_Clk, emitting a one-cycle Step pulse per tick.
module ee354_project_dirn_queue #(
  parameter int         DEPTH     = 4,
  parameter logic [1:0] INIT_DIRN = 2'b11
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         SCEN,
  input  logic [1:0]                   In_Dirn,
  input  logic                         Speed_Clk,
  input  logic                         q_Run,
  output logic [1:0]                   Cur_Dirn,
  output logic                         Step,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full,
  output logic                         Empty,
  output logic                         Dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [1:0]    curDirn_q, curDirn_d;
  logic          step_q, step_d;
  logic          dropped_q, dropped_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic          speedClkD_q;
  logic [1:0]    mem_q [DEPTH];

  logic          tick;
  logic          isFull;
  logic          isEmpty;
  logic [PW-1:0] tailPtr;
  logic [1:0]    lastDirn;
  logic          pushOk;
  logic          memWe;

  assign tick    = Speed_Clk & ~speedClkD_q;
  assign isFull  = (count_q == FULL_COUNT);
  assign isEmpty = (count_q == '0);
  assign tailPtr = wrPtr_q - PW'(1);

  // Presses are judged against the newest queued heading, or the committed one when nothing is queued
  always_comb begin
    lastDirn = curDirn_q;
    if (!isEmpty) lastDirn = mem_q[tailPtr];
  end

  // A press is legal only if it neither repeats nor reverses the reference heading
  assign pushOk = SCEN & q_Run & (In_Dirn != lastDirn) & (In_Dirn != (lastDirn ^ 2'b01));

  // Next-state: flush when not running, otherwise pop/commit on tick and queue legal presses
  always_comb begin
    curDirn_d = curDirn_q;
    count_d   = count_q;
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    step_d    = 1'b0;
    dropped_d = 1'b0;
    memWe     = 1'b0;
    if (!q_Run) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else if (tick) begin
      step_d = 1'b1;
      if (isEmpty) begin
        if (pushOk) curDirn_d = In_Dirn;
      end else begin
        curDirn_d = mem_q[rdPtr_q];
        rdPtr_d   = rdPtr_q + PW'(1);
        if (pushOk) begin
          memWe   = 1'b1;
          wrPtr_d = wrPtr_q + PW'(1);
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    end else if (pushOk) begin
      if (isFull) begin
        dropped_d = 1'b1;
      end else begin
        memWe   = 1'b1;
        wrPtr_d = wrPtr_q + PW'(1);
        count_d = count_q + CW'(1);
      end
    end
  end

  // Control state register; the Speed_Clk history resets high so release never fakes a tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      curDirn_q   <= INIT_DIRN;
      step_q      <= 1'b0;
      dropped_q   <= 1'b0;
      count_q     <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      speedClkD_q <= 1'b1;
    end else begin
      curDirn_q   <= curDirn_d;
      step_q      <= step_d;
      dropped_q   <= dropped_d;
      count_q     <= count_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      speedClkD_q <= Speed_Clk;
    end
  end

  // Queue storage; contents are meaningless once Count is cleared, so no reset is needed
  always_ff @(posedge Clk) begin
    if (!Reset && memWe) mem_q[wrPtr_q] <= In_Dirn;
  end

  assign Cur_Dirn = curDirn_q;
  assign Step     = step_q;
  assign Count    = count_q;
  assign Full     = isFull;
  assign Empty    = isEmpty;
  assign Dropped  = dropped_q;

endmodule

// File: tb/tb_ee354_project_dirn_queue.sv
// Scoreboard bench for the direction queue: stimulus pushes the expected
// Step/Dropped responses, a negedge monitor pops and compares them.
module tb_ee354_project_dirn_queue;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       SCEN;
  logic [1:0] In_Dirn;
  logic       Speed_Clk;
  logic       q_Run;
  logic [1:0] Cur_Dirn;
  logic       Step;
  logic [2:0] Count;
  logic       Full;
  logic       Empty;
  logic       Dropped;

  typedef struct {
    logic [1:0] dirn;
    int         count;
  } stepExp_t;

  stepExp_t stepQ[$];
  int       dropQ[$];
  int       checks   = 0;
  int       failures = 0;

  ee354_project_dirn_queue #(.DEPTH(4), .INIT_DIRN(2'b11)) dut (
    .Clk(Clk), .Reset(Reset), .SCEN(SCEN), .In_Dirn(In_Dirn),
    .Speed_Clk(Speed_Clk), .q_Run(q_Run), .Cur_Dirn(Cur_Dirn), .Step(Step),
    .Count(Count), .Full(Full), .Empty(Empty), .Dropped(Dropped)
  );

  // 100 MHz system clock
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every Step or Dropped pulse must match the oldest pending expectation
  always @(negedge Clk) begin
    if (Step === 1'b1) begin
      if (stepQ.size() == 0) begin
        checkOutput("unexpectedStep", 1, 0);
      end else begin
        stepExp_t e;
        e = stepQ.pop_front();
        checkOutput("stepCurDirn", int'(Cur_Dirn), int'(e.dirn));
        checkOutput("stepCount", int'(Count), e.count);
      end
    end
    if (Dropped === 1'b1) begin
      if (dropQ.size() == 0) begin
        checkOutput("unexpectedDropped", 1, 0);
      end else begin
        int c;
        c = dropQ.pop_front();
        checkOutput("droppedCount", int'(Count), c);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic applyStimulus(input logic [1:0] dir);
    SCEN    = 1'b1;
    In_Dirn = dir;
    cyc();
    SCEN    = 1'b0;
  endtask

  // Produce one Speed_Clk rise; optionally press on the tick cycle
  task automatic tickWith(input logic [1:0] expDir, input int expCount,
                          input bit withPress, input logic [1:0] dir);
    stepExp_t e;
    Speed_Clk = 1'b0;
    cyc();
    e.dirn  = expDir;
    e.count = expCount;
    stepQ.push_back(e);
    Speed_Clk = 1'b1;
    if (withPress) begin
      SCEN    = 1'b1;
      In_Dirn = dir;
    end
    cyc();
    SCEN = 1'b0;
    cyc();
  endtask

  initial begin
    Reset = 1'b1; SCEN = 1'b0; In_Dirn = 2'b00; Speed_Clk = 1'b1; q_Run = 1'b1;
    idle(3);
    checkOutput("resetCurDirn", int'(Cur_Dirn), 3);
    checkOutput("resetCount", int'(Count), 0);
    checkOutput("resetEmpty", int'(Empty), 1);
    checkOutput("resetStep", int'(Step), 0);
    Reset = 1'b0;
    idle(10);
    checkOutput("idleCurDirn", int'(Cur_Dirn), 3);
    checkOutput("idleEmpty", int'(Empty), 1);

    // Reversal and duplicate rejected, UP queued
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    checkOutput("rejectCount", int'(Count), 0);
    applyStimulus(2'b00);
    checkOutput("acceptCount", int'(Count), 1);
    tickWith(2'b00, 0, 0, 2'b00);
    checkOutput("commitCurDirn", int'(Cur_Dirn), 0);

    // Fill the queue, then overflow
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    checkOutput("fillCount", int'(Count), 4);
    checkOutput("fillFull", int'(Full), 1);
    applyStimulus(2'b00);
    dropQ.push_back(4);
    applyStimulus(2'b10);
    cyc();
    checkOutput("dropCount", int'(Count), 4);
    tickWith(2'b10, 3, 0, 2'b00);
    tickWith(2'b01, 2, 0, 2'b00);
    tickWith(2'b11, 1, 0, 2'b00);
    tickWith(2'b01, 0, 0, 2'b00);
    checkOutput("drainEmpty", int'(Empty), 1);

    // Full queue with press on the tick: pop and push together
    applyStimulus(2'b10);
    applyStimulus(2'b00);
    applyStimulus(2'b11);
    applyStimulus(2'b00);
    checkOutput("refillFull", int'(Full), 1);
    tickWith(2'b10, 4, 1, 2'b10);
    checkOutput("fullTickCount", int'(Count), 4);
    tickWith(2'b00, 3, 0, 2'b00);
    tickWith(2'b11, 2, 0, 2'b00);
    tickWith(2'b00, 1, 0, 2'b00);
    tickWith(2'b10, 0, 0, 2'b00);

    // Bring heading back to RIGHT, then bypass on an empty tick
    applyStimulus(2'b00);
    tickWith(2'b00, 0, 0, 2'b00);
    applyStimulus(2'b11);
    tickWith(2'b11, 0, 0, 2'b00);
    tickWith(2'b01, 0, 1, 2'b01);
    checkOutput("bypassCount", int'(Count), 0);
    checkOutput("bypassEmpty", int'(Empty), 1);

    // Mid-game reset discards queued entries
    applyStimulus(2'b10);
    applyStimulus(2'b00);
    checkOutput("preResetCount", int'(Count), 2);
    Reset = 1'b1;
    idle(5);
    Reset = 1'b0;
    cyc();
    checkOutput("midResetCount", int'(Count), 0);
    checkOutput("midResetCurDirn", int'(Cur_Dirn), 3);

    // Not running: presses and ticks ignored, heading held
    q_Run = 1'b0;
    applyStimulus(2'b00);
    applyStimulus(2'b01);
    Speed_Clk = 1'b0;
    cyc();
    Speed_Clk = 1'b1;
    idle(3);
    checkOutput("stopCount", int'(Count), 0);
    checkOutput("stopCurDirn", int'(Cur_Dirn), 3);

    // Dropping q_Run flushes a non-empty queue
    q_Run = 1'b1;
    applyStimulus(2'b00);
    checkOutput("runQueued", int'(Count), 1);
    q_Run = 1'b0;
    cyc();
    checkOutput("flushCount", int'(Count), 0);
    q_Run = 1'b1;
    idle(4);

    checkOutput("pendingSteps", stepQ.size(), 0);
    checkOutput("pendingDrops", dropQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
